// File: rtl/pam4_ber_checker.sv
// PAM-4 PRBS7 bit-error-rate checker: acquires lock on the received stream,
// then counts checked bits and bit errors. Define PAM4_BER_GRAY_EN to Gray-decode symbols.
module pam4_ber_checker #(
  parameter int unsigned LOCK_SYMS   = 16,
  parameter int unsigned UNLOCK_ERRS = 8,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [1:0]       symbol_in,
  input  logic             symbol_in_valid,
  input  logic             clear,
  output logic             locked,
  output logic [CNT_W-1:0] bit_count,
  output logic [CNT_W-1:0] err_count,
  output logic             sym_err
);

  localparam int unsigned MW = $clog2(LOCK_SYMS + 1);
  localparam logic [6:0]  UE = 7'(UNLOCK_ERRS);

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t           state, state_nx;
  logic [6:0]       s, s_nx;
  logic [MW-1:0]    match_cnt, match_nx;
  logic [5:0]       win_cnt, win_nx;
  logic [6:0]       win_errs, werr_nx, werr_inc;
  logic [CNT_W-1:0] bit_nx, err_nx;
  logic             serr_nx;
  logic [1:0]       rx, pred, diff, nerr;
  logic [CNT_W:0]   bit_sum, err_sum;

`ifdef PAM4_BER_GRAY_EN
  assign rx = {symbol_in[1], symbol_in[1] ^ symbol_in[0]};
`else
  assign rx = symbol_in;
`endif

  // Two PRBS7 steps: first predicted bit pairs with symbol_in[1]
  assign pred     = {s[6] ^ s[5], s[5] ^ s[4]};
  assign diff     = rx ^ pred;
  assign nerr     = {1'b0, diff[1]} + {1'b0, diff[0]};
  assign bit_sum  = {1'b0, bit_count} + (CNT_W+1)'(2);
  assign err_sum  = {1'b0, err_count} + (CNT_W+1)'(nerr);
  assign werr_inc = win_errs + 7'd1;
  assign locked   = (state == LOCKED);

  always_comb begin
    state_nx = state;
    s_nx     = s;
    match_nx = match_cnt;
    win_nx   = win_cnt;
    werr_nx  = win_errs;
    bit_nx   = bit_count;
    err_nx   = err_count;
    serr_nx  = 1'b0;
    if (symbol_in_valid) begin
      unique case (state)
        SEARCH: begin
          s_nx = {s[4:0], rx};
          if (diff == '0 && s != '0) match_nx = match_cnt + MW'(1);
          else                       match_nx = '0;
          if (match_nx == MW'(LOCK_SYMS)) begin
            state_nx = LOCKED;
            match_nx = '0;
          end
        end
        LOCKED: begin
          s_nx    = {s[4:0], pred};
          serr_nx = |diff;
          bit_nx  = bit_sum[CNT_W] ? '1 : bit_sum[CNT_W-1:0];
          err_nx  = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
          win_nx  = win_cnt + 6'd1;
          // The unlocking symbol itself is still counted above
          if (|diff && werr_inc >= UE) begin
            state_nx = SEARCH;
            match_nx = '0;
            win_nx   = '0;
            werr_nx  = '0;
          end else if (win_cnt == 6'd63) begin
            werr_nx = '0;
          end else if (|diff) begin
            werr_nx = werr_inc;
          end
        end
        default: state_nx = SEARCH;
      endcase
    end
    if (clear) begin
      bit_nx = '0;
      err_nx = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= SEARCH;
      s         <= '0;
      match_cnt <= '0;
      win_cnt   <= '0;
      win_errs  <= '0;
      bit_count <= '0;
      err_count <= '0;
      sym_err   <= 1'b0;
    end else begin
      state     <= state_nx;
      s         <= s_nx;
      match_cnt <= match_nx;
      win_cnt   <= win_nx;
      win_errs  <= werr_nx;
      bit_count <= bit_nx;
      err_count <= err_nx;
      sym_err   <= serr_nx;
    end
  end

endmodule

// File: tb/tb_pam4_ber_checker.sv
// Scoreboard bench for pam4_ber_checker: default build plus a CNT_W=4 instance on shared stimulus.
module tb_pam4_ber_checker;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [1:0]  symbol_in = '0;
  logic        symbol_in_valid = 1'b0;
  logic        clear = 1'b0;
  logic        locked, sym_err;
  logic [31:0] bit_count, err_count;
  logic        s_locked, s_sym_err;
  logic [3:0]  s_bit_count, s_err_count;

  always #5 clk = ~clk;

  pam4_ber_checker dut (
    .clk(clk), .rstn(rstn), .symbol_in(symbol_in), .symbol_in_valid(symbol_in_valid),
    .clear(clear), .locked(locked), .bit_count(bit_count), .err_count(err_count),
    .sym_err(sym_err)
  );

  pam4_ber_checker #(.CNT_W(4)) dut_small (
    .clk(clk), .rstn(rstn), .symbol_in(symbol_in), .symbol_in_valid(symbol_in_valid),
    .clear(clear), .locked(s_locked), .bit_count(s_bit_count), .err_count(s_err_count),
    .sym_err(s_sym_err)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: unsaturated counts, saturated per width when compared
  bit         m_lk;
  bit [6:0]   m_s;
  int         m_match, m_win, m_ewin;
  longint     m_bits, m_errs;
  bit         m_se;

  function automatic void model_step(bit r, bit v, bit c, bit [1:0] sym);
    bit [6:0] t;
    bit [1:0] p;
    int d;
    bit was_zero;
    if (!r) begin
      m_lk = 0; m_s = '0; m_match = 0; m_win = 0; m_ewin = 0;
      m_bits = 0; m_errs = 0; m_se = 0;
      return;
    end
    m_se = 0;
    if (v) begin
      t = m_s;
      for (int i = 1; i >= 0; i--) begin
        p[i] = t[6] ^ t[5];
        t = {t[5:0], p[i]};
      end
      d = int'(p[1] != sym[1]) + int'(p[0] != sym[0]);
      if (!m_lk) begin
        was_zero = (m_s == 0);
        m_s = {m_s[5:0], sym[1]};
        m_s = {m_s[5:0], sym[0]};
        if (d == 0 && !was_zero) m_match++; else m_match = 0;
        if (m_match == 16) begin m_lk = 1; m_match = 0; end
      end else begin
        m_s = t;
        m_bits += 2;
        m_errs += d;
        m_se = (d != 0);
        m_win++;
        if (d != 0) m_ewin++;
        if (m_ewin == 8) begin
          m_lk = 0; m_win = 0; m_ewin = 0; m_match = 0;
        end else if (m_win == 64) begin
          m_win = 0; m_ewin = 0;
        end
      end
    end
    if (c) begin m_bits = 0; m_errs = 0; end
  endfunction

  function automatic longint sat(longint x, longint maxv);
    return (x > maxv) ? maxv : x;
  endfunction

  typedef struct {
    int     cyc;
    bit     lk;
    longint bits;
    longint errs;
    bit     se;
  } exp_t;

  exp_t q[$];

  // Monitor: compares every clocked output against the entry for that edge
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      if (e.cyc != cyc) check("sb_sync", cyc, e.cyc);
      check("locked",      locked,      e.lk);
      check("bit_count",   bit_count,   sat(e.bits, 64'hFFFF_FFFF));
      check("err_count",   err_count,   sat(e.errs, 64'hFFFF_FFFF));
      check("sym_err",     sym_err,     e.se);
      check("s_locked",    s_locked,    e.lk);
      check("s_bit_count", s_bit_count, sat(e.bits, 15));
      check("s_err_count", s_err_count, sat(e.errs, 15));
      check("s_sym_err",   s_sym_err,   e.se);
    end
  end

  bit [6:0] g = 7'h7F;

  function automatic bit [1:0] gen();
    bit [1:0] r;
    for (int i = 1; i >= 0; i--) begin
      r[i] = g[6] ^ g[5];
      g = {g[5:0], r[i]};
    end
    return r;
  endfunction

  // Drive one edge; returns #1 after the sampling edge
  task automatic step(input bit r, input bit v, input bit c, input bit [1:0] sym);
    exp_t e;
    rstn = r; symbol_in_valid = v; clear = c; symbol_in = sym;
    model_step(r, v, c, sym);
    e.cyc = cyc + 1; e.lk = m_lk; e.bits = m_bits; e.errs = m_errs; e.se = m_se;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic clean_sym();
    step(1'b1, 1'b1, 1'b0, gen());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int fell;
    bit [1:0] sy;

    @(posedge clk); #1;
    repeat (2) step(1'b0, 1'b1, 1'b1, 2'b11);

    n = 0;
    do begin clean_sym(); n++; end while (!locked && n < 200);
    check("lock_syms", n, 20);

    for (int i = 0; i < 100; i++) begin
      if (i % 10 == 5) step(1'b1, 1'b0, 1'b0, 2'b10);
      clean_sym();
    end
    check("bits_after_100", bit_count, 200);
    check("errs_after_100", err_count, 0);
    check("small_saturated", s_bit_count, 15);

    sy = gen() ^ 2'b11;
    step(1'b1, 1'b1, 1'b0, sy);
    check("flip_sym_err", sym_err, 1);
    check("flip_err_count", err_count, 2);
    check("flip_locked", locked, 1);
    clean_sym();
    check("flip_pulse_end", sym_err, 0);
    repeat (29) clean_sym();

    fell = -1;
    for (int k = 0; k < 10; k++) begin
      sy = gen();
      if (k != 4 && k != 8) sy = sy ^ 2'b01;
      step(1'b1, 1'b1, 1'b0, sy);
      if (!locked && fell < 0) fell = k;
    end
    check("unlock_pos", fell, 9);
    check("unlock_bits", bit_count, 282);
    check("unlock_errs", err_count, 10);

    n = 0;
    do begin clean_sym(); n++; end while (!locked && n < 200);
    check("relock_syms", n, 16);
    check("relock_bits_held", bit_count, 282);

    clean_sym();
    step(1'b1, 1'b1, 1'b1, gen());
    check("clear_bits", bit_count, 0);
    check("clear_errs", err_count, 0);
    clean_sym();
    check("post_clear_bits", bit_count, 2);

    step(1'b0, 1'b0, 1'b0, 2'b00);
    repeat (50) step(1'b1, 1'b1, 1'b0, 2'b00);
    check("zeros_locked", locked, 0);

    n = 0;
    do begin clean_sym(); n++; end while (!locked && n < 60);
    check("zeros_relock", locked, 1);
    repeat (3) clean_sym();
    step(1'b1, 1'b1, 1'b0, gen() ^ 2'b10);
    step(1'b0, 1'b1, 1'b0, gen());
    check("rst_locked", locked, 0);
    check("rst_bits", bit_count, 0);
    check("rst_errs", err_count, 0);
    check("rst_sym_err", sym_err, 0);
    repeat (4) clean_sym();

    step(1'b1, 1'b0, 1'b0, 2'b00);
    repeat (3) @(posedge clk);
    check("sb_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pam4_ber_checker.md
PAM4_BER_CHECKER -- requirements
Module: pam4_ber_checker

Interface
REQ-001 The block SHALL have parameter LOCK_SYMS, default 16: consecutive matching symbols required to declare lock.
REQ-002 The block SHALL have parameter UNLOCK_ERRS, default 8: errored symbols within one 64-symbol window that force loss of lock.
REQ-003 The block SHALL have parameter CNT_W, default 32: width of bit and error counters.
REQ-004 The block SHALL have port clk  input  1  the single clock; all logic is on the rising edge.
REQ-005 The block SHALL have port rstn  input  1  reset, synchronous and active-low.
REQ-006 The block SHALL have port symbol_in  input  2  decoded PAM-4 symbol from the upstream decoder.
REQ-007 The block SHALL have port symbol_in_valid  input  1  qualifies symbol_in for one cycle.
REQ-008 The block SHALL have port clear  input  1  synchronous clear of bit_count and err_count.
REQ-009 The block SHALL have port locked  output  1  high while in LOCKED.
REQ-010 The block SHALL have port bit_count  output  CNT_W  bits checked while locked.
REQ-011 The block SHALL have port err_count  output  CNT_W  bit errors found while locked.
REQ-012 The block SHALL have port sym_err  output  1  one-cycle pulse on an errored symbol while locked.

Function
REQ-013 The reference sequence SHALL be PRBS7: 7-bit state s, next bit = s[6]^s[5], shifted into s[0]; each symbol carries 2 bits, symbol_in[1] first.
REQ-014 Cycles with symbol_in_valid low SHALL change no state, counter or output, except that sym_err returns low.
REQ-015 FSM states SHALL be SEARCH and LOCKED.
REQ-016 In SEARCH, each valid symbol SHALL be compared with the two predicted bits, and both received bits SHALL then be shifted into s.
REQ-017 In SEARCH, a match SHALL increment match_cnt, and a mismatch, or a state of all zeros before the shift, SHALL clear match_cnt to 0.
REQ-018 When match_cnt reaches LOCK_SYMS, the FSM SHALL go to LOCKED on that same edge, and locked SHALL be high from the next cycle.
REQ-019 In LOCKED, s SHALL advance from its own predicted bits and SHALL NOT reload from received data.
REQ-020 In LOCKED, each valid symbol SHALL add 2 to bit_count and the number of differing bits (0, 1 or 2) to err_count, and a nonzero difference SHALL pulse sym_err high for exactly the following cycle.
REQ-021 Counters SHALL saturate at all-ones and SHALL NOT wrap.
REQ-022 In LOCKED, a 6-bit window counter SHALL count valid symbols, and errored symbols in the window SHALL be counted.
REQ-023 If the window's errored-symbol count reaches UNLOCK_ERRS, the FSM SHALL go to SEARCH, clear match_cnt and hold bit_count and err_count.
REQ-024 On window wrap (64 symbols) without reaching UNLOCK_ERRS, the errored-symbol count SHALL reset to 0.
REQ-025 The symbol that reaches UNLOCK_ERRS SHALL be counted in bit_count and err_count.
REQ-026 Counters SHALL NOT change in SEARCH.
REQ-027 If clear and symbol_in_valid are high together, clear SHALL win: both counters become 0 and that symbol adds nothing to them; FSM and LFSR behaviour are unaffected.
REQ-028 Output latency SHALL be 1 cycle from the symbol_in_valid sampling edge to the updated bit_count, err_count, sym_err and locked.

Reset
REQ-029 With rstn low at a clock edge, the block SHALL set state = SEARCH, s = 0, match_cnt = 0, window counters = 0, locked = 0, bit_count = 0, err_count = 0 and sym_err = 0.
REQ-030 Reset SHALL override clear and symbol_in_valid.
REQ-031 Reset in mid-operation SHALL drop lock immediately, and relock SHALL require LOCK_SYMS fresh matches.

Configuration
REQ-032 When the macro PAM4_BER_GRAY_EN is defined, symbol_in SHALL be Gray-decoded before bit extraction (00->00, 01->01, 11->10, 10->11).
REQ-033 When PAM4_BER_GRAY_EN is undefined, symbol_in bits SHALL be used directly; all other behaviour is identical.

Verification
REQ-034 Reset, then feed a continuous PRBS7 symbol stream seeded 7'h7F -> locked rises 1 cycle after the 16th matching symbol; after 100 further symbols bit_count = 200 and err_count = 0.
REQ-035 While locked, flip both bits of one symbol -> sym_err pulses once, err_count = 2, and locked stays 1.
REQ-036 While locked, corrupt 8 of the next 10 symbols -> locked falls after the 8th errored symbol; counters hold; a clean stream relocks after 16 matches.
REQ-037 Feed all-zero symbols for 50 cycles -> locked stays 0 and match_cnt stays 0.
REQ-038 Assert clear together with symbol_in_valid while locked -> bit_count = 0 and err_count = 0 next cycle; the following clean symbol gives bit_count = 2.
REQ-039 Preload bit_count near saturation (CNT_W = 4 build) -> bit_count holds 4'hF with no wrap; assert rstn low mid-stream -> all outputs 0 next cycle.
